// File: rtl/queue_fifo_pkg.sv
// Shared definitions for the queue FIFO and the LIFO stack: default sizes,
// the wrap-around pointer increment and the occupancy counter width.
package queue_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 4;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap at depth-1 so non-power-of-two depths index correctly.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/queue_fifo.sv
// Circular-buffer FIFO with occupancy count, sticky error flags and a
// registered read port (one-cycle pop-to-data latency).
module queue_fifo
    import queue_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         write_data,
    output logic [DATA_WIDTH-1:0]         read_data,
    output logic                          read_valid,
    output logic                          full,
    output logic                          empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvld_q, rvld_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  push_ok, pop_ok;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    // A full FIFO still accepts a push when a pop frees the slot in the same edge.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvld_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
            end
            if (pop_ok) begin
                rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
                rdata_d  = mem[rd_ptr_q];
                rvld_d   = 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                cnt_d = cnt_q - 1'b1;
            end
            ovf_d = ovf_q | (push & full & ~pop);
            unf_d = unf_q | (pop & empty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvld_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvld_q   <= rvld_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_q] <= write_data;
        end
    end

    assign read_data  = rdata_q;
    assign read_valid = rvld_q;
    assign count      = cnt_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_queue_fifo.sv
// Directed self-checking bench for queue_fifo at DATA_WIDTH=8, DEPTH=4.
module tb_queue_fifo;

    logic       clk;
    logic       rst_n;
    logic       push;
    logic       pop;
    logic       flush;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       read_valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    queue_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of strobes; returns 1 time unit after the edge.
    task automatic cyc(input logic p, input logic q, input logic f, input logic [7:0] d);
        push       = p;
        pop        = q;
        flush      = f;
        write_data = d;
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic check_idle_state(input string tag, input logic [7:0] exp_rd);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_rvalid"}, 32'(read_valid), 0);
        check({tag, "_rdata"}, 32'(read_data), 32'(exp_rd));
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_unf"}, 32'(underflow), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        write_data = 8'h00;
        #12;
        check_idle_state("reset", 8'h00);
        rst_n = 1'b1;

        // Basic ordering
        cyc(1, 0, 0, 8'h11);
        cyc(1, 0, 0, 8'h22);
        cyc(1, 0, 0, 8'h33);
        check("t1_count3", 32'(count), 3);
        check("t1_rv_before_pop", 32'(read_valid), 0);
        cyc(0, 1, 0, 8'h00);
        check("t1_rd0", 32'(read_data), 32'h11);
        check("t1_rv0", 32'(read_valid), 1);
        cyc(0, 1, 0, 8'h00);
        check("t1_rd1", 32'(read_data), 32'h22);
        check("t1_rv1", 32'(read_valid), 1);
        cyc(0, 1, 0, 8'h00);
        check("t1_rd2", 32'(read_data), 32'h33);
        check("t1_rv2", 32'(read_valid), 1);
        check("t1_empty", 32'(empty), 1);
        cyc(0, 0, 0, 8'h00);
        check("t1_rv_drop", 32'(read_valid), 0);
        check("t1_rd_hold", 32'(read_data), 32'h33);

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'hA0 + 8'(i));
        check("t2_full", 32'(full), 1);
        check("t2_count4", 32'(count), 4);
        cyc(1, 0, 0, 8'hFF);
        check("t2_ovf", 32'(overflow), 1);
        check("t2_count_stay", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 8'h00);
            check($sformatf("t2_rd%0d", i), 32'(read_data), 32'hA0 + i);
        end
        check("t2_empty", 32'(empty), 1);
        check("t2_ovf_sticky", 32'(overflow), 1);
        cyc(0, 0, 1, 8'h00);
        check("t2_flush_ovf", 32'(overflow), 0);

        // Push+pop while full
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'hA0 + 8'(i));
        cyc(1, 1, 0, 8'h55);
        check("t3_rd", 32'(read_data), 32'hA0);
        check("t3_rv", 32'(read_valid), 1);
        check("t3_count", 32'(count), 4);
        check("t3_full", 32'(full), 1);
        check("t3_no_ovf", 32'(overflow), 0);
        cyc(0, 1, 0, 8'h00);
        check("t3_d0", 32'(read_data), 32'hA1);
        cyc(0, 1, 0, 8'h00);
        check("t3_d1", 32'(read_data), 32'hA2);
        cyc(0, 1, 0, 8'h00);
        check("t3_d2", 32'(read_data), 32'hA3);
        cyc(0, 1, 0, 8'h00);
        check("t3_d3", 32'(read_data), 32'h55);
        check("t3_empty", 32'(empty), 1);

        // Push+pop while empty: no fall-through
        cyc(1, 1, 0, 8'h77);
        check("t4_unf", 32'(underflow), 1);
        check("t4_rv", 32'(read_valid), 0);
        check("t4_count", 32'(count), 1);
        check("t4_rd_hold", 32'(read_data), 32'h55);
        cyc(0, 1, 0, 8'h00);
        check("t4_rd", 32'(read_data), 32'h77);
        check("t4_rv2", 32'(read_valid), 1);
        check("t4_unf_sticky", 32'(underflow), 1);
        cyc(0, 0, 1, 8'h00);
        check("t4_flush_unf", 32'(underflow), 0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 8'(i));
            cyc(0, 1, 0, 8'h00);
            check($sformatf("t5_rd%0d", i), 32'(read_data), i);
        end
        check("t5_empty", 32'(empty), 1);
        check("t5_ovf", 32'(overflow), 0);
        check("t5_unf", 32'(underflow), 0);

        // Asynchronous reset mid-cycle with strobes outstanding
        cyc(0, 1, 0, 8'h00);
        check("t6_unf_set", 32'(underflow), 1);
        cyc(1, 0, 0, 8'hC1);
        cyc(1, 0, 0, 8'hC2);
        cyc(1, 0, 0, 8'hC3);
        check("t6_count3", 32'(count), 3);
        push       = 1'b1;
        pop        = 1'b1;
        write_data = 8'hEE;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_state("t6_async", 8'h00);
        push  = 1'b0;
        pop   = 1'b0;
        #2;
        rst_n = 1'b1;
        cyc(1, 0, 0, 8'hD0);
        check("t6_post_count", 32'(count), 1);
        cyc(0, 1, 0, 8'h00);
        check("t6_post_rd", 32'(read_data), 32'hD0);

        // Flush overrides push and pop in the same cycle
        cyc(1, 0, 0, 8'hE1);
        cyc(1, 0, 0, 8'hE2);
        cyc(1, 0, 0, 8'hE3);
        cyc(0, 1, 0, 8'h00);
        check("t7_rd", 32'(read_data), 32'hE1);
        cyc(1, 1, 1, 8'hEE);
        check_idle_state("t7_flush", 8'hE1);
        cyc(0, 1, 0, 8'h00);
        check("t7_pop_empty_unf", 32'(underflow), 1);
        check("t7_pop_empty_rv", 32'(read_valid), 0);
        cyc(0, 0, 1, 8'h00);
        cyc(1, 0, 0, 8'hF0);
        cyc(0, 1, 0, 8'h00);
        check("t7_post_rd", 32'(read_data), 32'hF0);
        check("t7_post_empty", 32'(empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/queue_fifo.md
Name: queue_fifo

Overview:
- First-in first-out buffer.
- It is the counterpart to the team's LIFO stack: data leaves from the opposite end to where it entered, so it is read back in write order.
- It is a circular buffer with read and write pointers, an occupancy counter, full/empty status, sticky error flags and a registered read port.
- It sits between producer and consumer blocks that use the same push/pop strobe interface as the stack.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 4, number of entries. Legal values are ≥ 2. Non-power-of-two values are legal.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  write strobe; write_data is stored this cycle.
- pop  input  1  read strobe; the oldest entry is removed this cycle.
- flush  input  1  synchronous clear of contents and pointers.
- write_data  input  DATA_WIDTH  word to store.
- read_data  output  DATA_WIDTH  registered word from the last accepted pop.
- read_valid  output  1  high for exactly one cycle after an accepted pop.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  sticky; set when a push is rejected.
- underflow  output  1  sticky; set when a pop is rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count are 0.
  - read_data = 0, read_valid = 0.
  - empty = 1, full = 0.
  - overflow = 0, underflow = 0.
  - Storage contents are not reset.
- Accept rules, evaluated on the pre-edge state:
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
- Push when full with pop high in the same cycle:
  - Both are accepted and count is unchanged.
  - Storage is not overwritten before the read: the read slot is captured into read_data in the same edge.
- Pop when empty with push high in the same cycle:
  - The pop is rejected, underflow is set, and the push is accepted.
  - There is no fall-through bypass.
- Write path: on push_ok, mem[wr_ptr] <= write_data and wr_ptr advances.
- Read path: on pop_ok, read_data <= mem[rd_ptr], rd_ptr advances, and read_valid <= 1 on the next cycle.
  - Read latency is one clock from pop to read_data/read_valid.
- When no pop is accepted:
  - read_valid <= 0.
  - read_data holds its last value.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap explicitly from DEPTH-1 to 0, so non-power-of-two depths work.
- Count update: count <= count + push_ok - pop_ok. It never exceeds DEPTH and never goes below 0.
- full and empty are decoded combinationally from the registered count; no extra latency.
- Error flags:
  - overflow is set on push & full & ~pop.
  - underflow is set on pop & empty.
  - Both are sticky until reset or flush.
- flush has priority over push and pop in the same cycle:
  - Pointers, count, read_valid, overflow and underflow are cleared.
  - read_data holds its value.
  - Any push or pop in that cycle is ignored and sets no flags.
- Reset asserted mid-operation forces the reset state immediately, whatever the outstanding strobes. The first edge after rst_n deasserts behaves as from empty.

Decomposition:
- Shared package holds:
  - the pointer-increment-with-wrap function;
  - the count width helper function clog2(DEPTH+1);
  - default DATA_WIDTH/DEPTH constants, shared with the stack.
- No sub-module is required. Storage is a plain register array inferred in-module. An optional wrapper, queue_fifo_ram, may later swap in block RAM without changing the port list.

Test Plan (all with DATA_WIDTH=8, DEPTH=4):
- Reset, then push 0x11,0x22,0x33 and pop ×3 → read_data 0x11,0x22,0x33 on the cycles after each pop; read_valid pulses ×3; empty=1 at end.
- Push 0xA0..0xA3 (full=1, count=4), then push 0xFF → overflow=1, count stays 4; pop ×4 → 0xA0..0xA3 in order.
- Fill to 4, then simultaneous push 0x55 + pop → read_data=0xA0, count stays 4, full stays 1; drain → 0xA1,0xA2,0xA3,0x55.
- Empty, simultaneous push 0x77 + pop → underflow=1, read_valid=0, count=1; next pop → 0x77.
- Wrap: push and pop 10 words 0x00..0x09 one at a time → every read matches and pointers wrap twice without error.
- Fill 3 entries, assert rst_n low mid-cycle (asynchronous) → count=0, empty=1, flags=0 immediately. Repeat with flush=1 + push → count=0 and the push is ignored.
